core_opfetch: RTL and testbench

Operand-fetch stage between decode and execute: accepts one decoded micro-op per cycle, issues synchronous reads to `core_regfile`, and presents both source operands to execute one cycle later. It tracks in-flight destination registers in a busy scoreboard, stalls decode on RAW hazards, forces x0 reads to zero, and optionally forwards same-cycle writebacks.

---
 rtl/core_pkg.sv | 19 +
 rtl/core_opfetch_if.sv | 47 ++++
 rtl/core_scoreboard.sv | 34 +++
 rtl/core_opfetch.sv | 97 +++++++++
 tb/tb_core_opfetch.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared widths and the held micro-op record for the operand-fetch stage
package core_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int NREGS   = 32;
    localparam int UOP_W   = 32;

    typedef struct packed {
        logic [RADDR_W-1:0] rs0_addr;
        logic [RADDR_W-1:0] rs1_addr;
        logic               rs0_use;
        logic               rs1_use;
        logic               rd_we;
        logic [RADDR_W-1:0] rd_addr;
        logic [UOP_W-1:0]   uop;
    } opfetch_uop_t;

endpackage

// File: rtl/core_opfetch_if.sv
// core_opfetch_if: decode, regfile, writeback and execute signals of the operand-fetch stage
interface core_opfetch_if;
    import core_pkg::*;

    logic               in_valid_i;
    logic               in_ready_o;
    logic [RADDR_W-1:0] in_rs0_addr_i;
    logic [RADDR_W-1:0] in_rs1_addr_i;
    logic               in_rs0_use_i;
    logic               in_rs1_use_i;
    logic               in_rd_we_i;
    logic [RADDR_W-1:0] in_rd_addr_i;
    logic [UOP_W-1:0]   in_uop_i;
    logic               rf_rs0_re_o;
    logic               rf_rs1_re_o;
    logic [RADDR_W-1:0] rf_rs0_addr_o;
    logic [RADDR_W-1:0] rf_rs1_addr_o;
    logic [XLEN-1:0]    rf_rs0_data_i;
    logic [XLEN-1:0]    rf_rs1_data_i;
    logic               wb_we_i;
    logic [RADDR_W-1:0] wb_addr_i;
    logic [XLEN-1:0]    wb_data_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [XLEN-1:0]    out_rs0_data_o;
    logic [XLEN-1:0]    out_rs1_data_o;
    logic               out_rd_we_o;
    logic [RADDR_W-1:0] out_rd_addr_o;
    logic [UOP_W-1:0]   out_uop_o;

    modport master (
        output in_valid_i, in_rs0_addr_i, in_rs1_addr_i, in_rs0_use_i, in_rs1_use_i,
               in_rd_we_i, in_rd_addr_i, in_uop_i, rf_rs0_data_i, rf_rs1_data_i,
               wb_we_i, wb_addr_i, wb_data_i, out_ready_i,
        input  in_ready_o, rf_rs0_re_o, rf_rs1_re_o, rf_rs0_addr_o, rf_rs1_addr_o,
               out_valid_o, out_rs0_data_o, out_rs1_data_o, out_rd_we_o, out_rd_addr_o, out_uop_o
    );

    modport slave (
        input  in_valid_i, in_rs0_addr_i, in_rs1_addr_i, in_rs0_use_i, in_rs1_use_i,
               in_rd_we_i, in_rd_addr_i, in_uop_i, rf_rs0_data_i, rf_rs1_data_i,
               wb_we_i, wb_addr_i, wb_data_i, out_ready_i,
        output in_ready_o, rf_rs0_re_o, rf_rs1_re_o, rf_rs0_addr_o, rf_rs1_addr_o,
               out_valid_o, out_rs0_data_o, out_rs1_data_o, out_rd_we_o, out_rd_addr_o, out_uop_o
    );

endinterface

// File: rtl/core_scoreboard.sv
// core_scoreboard: busy bits for in-flight destination registers with two lookup ports
module core_scoreboard
    import core_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               set_en,
    input  logic [RADDR_W-1:0] set_addr,
    input  logic               clr_en,
    input  logic [RADDR_W-1:0] clr_addr,
    input  logic               fclr_en,
    input  logic [RADDR_W-1:0] fclr_addr,
    input  logic [RADDR_W-1:0] rd0_addr,
    input  logic [RADDR_W-1:0] rd1_addr,
    output logic               rd0_busy,
    output logic               rd1_busy
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;

    assign set_mask = NREGS'(set_en && set_addr != '0) << set_addr;
    assign clr_mask = (NREGS'(clr_en) << clr_addr) | (NREGS'(fclr_en) << fclr_addr);
    assign rd0_busy = busy[rd0_addr];
    assign rd1_busy = busy[rd1_addr];

    // clears apply first so a same-cycle set of the same register wins
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) busy <= '0;
        else          busy <= (busy & ~clr_mask) | set_mask;
    end

endmodule

// File: rtl/core_opfetch.sv
// core_opfetch: operand-fetch stage with RAW scoreboard; CORE_OPFETCH_BYPASS_EN enables same-cycle writeback forwarding
module core_opfetch
    import core_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          flush_i,
    core_opfetch_if.slave bus
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]      state;
    opfetch_uop_t    held;
    logic            valid_q, accept, fire, hazard;
    logic            busy0, busy1, wb0, wb1, need0, need1;
    logic [XLEN-1:0] src0, src1;

    assign valid_q = state == FULL;
    assign need0   = bus.in_rs0_use_i && bus.in_rs0_addr_i != '0;
    assign need1   = bus.in_rs1_use_i && bus.in_rs1_addr_i != '0;
    assign wb0     = bus.wb_we_i && bus.wb_addr_i == bus.in_rs0_addr_i;
    assign wb1     = bus.wb_we_i && bus.wb_addr_i == bus.in_rs1_addr_i;
`ifdef CORE_OPFETCH_BYPASS_EN
    assign hazard  = (need0 && busy0 && !wb0) || (need1 && busy1 && !wb1);
`else
    assign hazard  = (need0 && (busy0 || wb0)) || (need1 && (busy1 || wb1));
`endif
    assign bus.in_ready_o    = !flush_i && (!valid_q || bus.out_ready_i) && !hazard;
    assign accept            = bus.in_valid_i && bus.in_ready_o;
    assign fire              = valid_q && bus.out_ready_i;
    assign bus.rf_rs0_re_o   = accept && bus.in_rs0_use_i;
    assign bus.rf_rs1_re_o   = accept && bus.in_rs1_use_i;
    assign bus.rf_rs0_addr_o = bus.in_rs0_addr_i;
    assign bus.rf_rs1_addr_o = bus.in_rs1_addr_i;

    core_scoreboard u_sb (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .set_en    (accept && bus.in_rd_we_i),
        .set_addr  (bus.in_rd_addr_i),
        .clr_en    (bus.wb_we_i),
        .clr_addr  (bus.wb_addr_i),
        .fclr_en   (flush_i && valid_q && held.rd_we),
        .fclr_addr (held.rd_addr),
        .rd0_addr  (bus.in_rs0_addr_i),
        .rd1_addr  (bus.in_rs1_addr_i),
        .rd0_busy  (busy0),
        .rd1_busy  (busy1)
    );

    // EMPTY/FULL: flush dominates, an accept refills, a lone fire drains
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= EMPTY;
        else          state <= flush_i ? EMPTY : accept ? FULL : fire ? EMPTY : state;
    end

    // capture the decoded fields of each accepted micro-op
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)    held <= '0;
        else if (accept) held <= '{bus.in_rs0_addr_i, bus.in_rs1_addr_i, bus.in_rs0_use_i,
                                   bus.in_rs1_use_i, bus.in_rd_we_i, bus.in_rd_addr_i, bus.in_uop_i};
    end

`ifdef CORE_OPFETCH_BYPASS_EN
    logic            fwd0, fwd1;
    logic [XLEN-1:0] fwd_data;

    // regfile returns the pre-write value when read and written together, so keep the writeback data
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fwd0     <= 1'b0;
            fwd1     <= 1'b0;
            fwd_data <= '0;
        end else if (accept) begin
            fwd0     <= need0 && wb0;
            fwd1     <= need1 && wb1;
            fwd_data <= bus.wb_data_i;
        end
    end

    assign src0 = fwd0 ? fwd_data : bus.rf_rs0_data_i;
    assign src1 = fwd1 ? fwd_data : bus.rf_rs1_data_i;
`else
    assign src0 = bus.rf_rs0_data_i;
    assign src1 = bus.rf_rs1_data_i;
`endif

    assign bus.out_valid_o    = valid_q;
    assign bus.out_rs0_data_o = (held.rs0_addr == '0 || !held.rs0_use) ? '0 : src0;
    assign bus.out_rs1_data_o = (held.rs1_addr == '0 || !held.rs1_use) ? '0 : src1;
    assign bus.out_rd_we_o    = held.rd_we;
    assign bus.out_rd_addr_o  = held.rd_addr;
    assign bus.out_uop_o      = held.uop;

endmodule

// File: tb/tb_core_opfetch.sv
// tb_core_opfetch: directed scoreboard bench for core_opfetch with a behavioural regfile
module tb_core_opfetch;

    logic clk;
    logic rst_n;
    logic flush;

    core_opfetch_if bus ();

    core_opfetch dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .flush_i (flush),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] op0;
        logic [31:0] op1;
        logic        rd_we;
        logic [4:0]  rd;
        logic [31:0] uop;
    } exp_t;

    exp_t        q[$];
    logic [31:0] regs[32];
    int          vectors = 0;
    int          miscompares = 0;
    int          exp_lat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // regfile: synchronous read-before-write, output held while re is low
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= (i == 3) ? 32'd5 : (i == 4) ? 32'd7 : 32'h100 + i;
            bus.rf_rs0_data_i <= '0;
            bus.rf_rs1_data_i <= '0;
        end else begin
            if (bus.rf_rs0_re_o) bus.rf_rs0_data_i <= regs[bus.rf_rs0_addr_o];
            if (bus.rf_rs1_re_o) bus.rf_rs1_data_i <= regs[bus.rf_rs1_addr_o];
            if (bus.wb_we_i) regs[bus.wb_addr_i] <= bus.wb_data_i;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic use_, input logic [4:0] a);
        if (!use_ || a == 5'd0) return 32'd0;
        return (bus.wb_we_i && bus.wb_addr_i == a) ? bus.wb_data_i : regs[a];
    endfunction

    task automatic idle();
        bus.in_valid_i = 0; bus.in_rs0_addr_i = 0; bus.in_rs1_addr_i = 0;
        bus.in_rs0_use_i = 0; bus.in_rs1_use_i = 0; bus.in_rd_we_i = 0;
        bus.in_rd_addr_i = 0; bus.in_uop_i = 0; bus.wb_we_i = 0;
        bus.wb_addr_i = 0; bus.wb_data_i = 0; bus.out_ready_i = 1; flush = 0;
    endtask

    task automatic drive(input logic [4:0] rs0, input logic [4:0] rs1, input logic u0, input logic u1,
                         input logic we, input logic [4:0] rd, input logic [31:0] uop);
        bus.in_valid_i = 1; bus.in_rs0_addr_i = rs0; bus.in_rs1_addr_i = rs1;
        bus.in_rs0_use_i = u0; bus.in_rs1_use_i = u1; bus.in_rd_we_i = we;
        bus.in_rd_addr_i = rd; bus.in_uop_i = uop;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bus.wb_we_i = 1; bus.wb_addr_i = a; bus.wb_data_i = d;
    endtask

    task automatic settle();
        #4;
    endtask

    // just before the edge: retire a fired uop against the queue, record an accepted one
    task automatic adv();
        exp_t e;
        if (bus.out_valid_o && bus.out_ready_i && !flush) begin
            chk("fire_has_expect", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("op0", bus.out_rs0_data_o, e.op0);
                chk("op1", bus.out_rs1_data_o, e.op1);
                chk("rd_we", 32'(bus.out_rd_we_o), 32'(e.rd_we));
                chk("rd", 32'(bus.out_rd_addr_o), 32'(e.rd));
                chk("uop", bus.out_uop_o, e.uop);
            end
        end
        if (flush && bus.out_valid_o && q.size() != 0) void'(q.pop_front());
        if (bus.in_valid_i && bus.in_ready_o)
            q.push_back('{ref_op(bus.in_rs0_use_i, bus.in_rs0_addr_i), ref_op(bus.in_rs1_use_i, bus.in_rs1_addr_i),
                          bus.in_rd_we_i, bus.in_rd_addr_i, bus.in_uop_i});
        @(negedge clk);
    endtask

    task automatic tick();
        settle();
        adv();
    endtask

    // writeback releases the stalled uop; count cycles from the writeback cycle to its accept
    task automatic wait_accept(input string tag, input logic [4:0] a, input logic [31:0] d);
        int lat = -1;
        wb(a, d);
        for (int k = 0; k < 4 && lat < 0; k++) begin
            settle();
            if (bus.in_ready_o) lat = k;
            adv();
            bus.wb_we_i = 0;
        end
        bus.in_valid_i = 0;
        chk(tag, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
`ifdef CORE_OPFETCH_BYPASS_EN
        exp_lat = 0;
`else
        exp_lat = 1;
`endif
        idle();
        rst_n = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_op0", bus.out_rs0_data_o, 32'd0);
        chk("rst_op1", bus.out_rs1_data_o, 32'd0);
        chk("rst_rd_we", 32'(bus.out_rd_we_o), 32'd0);
        chk("rst_uop", bus.out_uop_o, 32'd0);
        chk("rst_ready", 32'(bus.in_ready_o), 32'd1);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        drive(3, 4, 1, 1, 1, 8, 32'hA);
        settle();
        chk("a_ready", 32'(bus.in_ready_o), 32'd1);
        chk("a_re0", 32'(bus.rf_rs0_re_o), 32'd1);
        chk("a_addr1", 32'(bus.rf_rs1_addr_o), 32'd4);
        adv();
        drive(0, 0, 0, 0, 1, 5, 32'hB);
        settle();
        chk("a_valid", 32'(bus.out_valid_o), 32'd1);
        chk("a_busy8", 32'(dut.u_sb.busy[8]), 32'd1);
        adv();

        drive(5, 3, 1, 1, 0, 0, 32'hC);
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("c_stall", 32'(bus.in_ready_o), 32'd0);
            adv();
        end
        wait_accept("c_release_lat", 5, 32'h11);
        tick();

        wb(0, 32'hFFFF);
        drive(0, 0, 1, 1, 0, 0, 32'h40);
        settle();
        chk("x0_nostall", 32'(bus.in_ready_o), 32'd1);
        adv();
        bus.wb_we_i = 0;
        drive(0, 3, 1, 1, 0, 0, 32'h41);
        settle();
        chk("x0_ready", 32'(bus.in_ready_o), 32'd1);
        adv();

        drive(3, 4, 1, 1, 1, 9, 32'hD);
        tick();
        bus.out_ready_i = 0;
        drive(4, 0, 1, 0, 0, 0, 32'hE);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("bp_valid", 32'(bus.out_valid_o), 32'd1);
            chk("bp_op0", bus.out_rs0_data_o, 32'd5);
            chk("bp_op1", bus.out_rs1_data_o, 32'd7);
            chk("bp_uop", bus.out_uop_o, 32'hD);
            chk("bp_ready", 32'(bus.in_ready_o), 32'd0);
            chk("bp_re", 32'({bus.rf_rs0_re_o, bus.rf_rs1_re_o}), 32'd0);
            adv();
        end
        bus.out_ready_i = 1;
        settle();
        chk("bp_release", 32'(bus.in_ready_o), 32'd1);
        adv();

        drive(0, 0, 0, 0, 1, 6, 32'hF);
        tick();
        bus.in_valid_i = 0;
        bus.out_ready_i = 0;
        flush = 1;
        settle();
        chk("fl_busy6_before", 32'(dut.u_sb.busy[6]), 32'd1);
        chk("fl_ready", 32'(bus.in_ready_o), 32'd0);
        adv();
        flush = 0;
        bus.out_ready_i = 1;
        drive(6, 4, 1, 1, 0, 0, 32'h16);
        settle();
        chk("fl_valid", 32'(bus.out_valid_o), 32'd0);
        chk("fl_busy6", 32'(dut.u_sb.busy[6]), 32'd0);
        chk("fl_nostall", 32'(bus.in_ready_o), 32'd1);
        adv();

        drive(0, 0, 0, 0, 1, 7, 32'h17);
        wb(7, 32'h77);
        tick();
        bus.wb_we_i = 0;
        bus.in_valid_i = 0;
        settle();
        chk("sw_busy7", 32'(dut.u_sb.busy[7]), 32'd1);
        adv();
        drive(7, 0, 1, 0, 0, 0, 32'h18);
        settle();
        chk("sw_stall", 32'(bus.in_ready_o), 32'd0);
        adv();
        wait_accept("sw_release_lat", 7, 32'h99);
        tick();
        tick();
        chk("drain", 32'(q.size()), 32'd0);

        drive(0, 0, 0, 0, 1, 10, 32'h1A);
        tick();
        bus.in_valid_i = 0;
        bus.out_ready_i = 0;
        rst_n = 0;
        #1;
        chk("mrst_valid", 32'(bus.out_valid_o), 32'd0);
        chk("mrst_busy", dut.u_sb.busy, 32'd0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        idle();
        tick();
        chk("mrst_idle", 32'(bus.out_valid_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
